// File: rtl/main_mem_arb.sv
// Main-memory arbiter between the CPU memory stage and the debug/loader port.
// Round-robin on contention, with a bounded debug lock for back-to-back ownership.
module main_mem_arb #(
    parameter int ADDR_W   = 32,
    parameter int DAT_W    = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DAT_W-1:0]  cpu_wdat,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_lock,
    input  logic              dbg_wen,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DAT_W-1:0]  dbg_wdat,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DAT_W-1:0]  rd_dat,
    output logic              mem_cs,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DAT_W-1:0]  mem_dat_in,
    input  logic [DAT_W-1:0]  mem_dat_out
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_LOCK);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          forced_q, forced_d;
    logic          cpu_rv_q, cpu_rv_d;
    logic          dbg_rv_q, dbg_rv_d;

    // Grant decision: lock gives debug exclusive use, otherwise alternate on contention.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (state_q == LOCK) begin
            dbg_gnt = dbg_req;
        end else if (cpu_req && dbg_req) begin
            cpu_gnt = last_q;
            dbg_gnt = ~last_q;
        end else begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req;
        end
    end

    // Memory port mux from the granted requester; idle bus is all zero.
    always_comb begin
        mem_cs     = cpu_gnt | dbg_gnt;
        mem_wen    = 1'b0;
        mem_addr   = '0;
        mem_dat_in = '0;
        if (cpu_gnt) begin
            mem_wen    = cpu_wen;
            mem_addr   = cpu_addr;
            mem_dat_in = cpu_wdat;
        end else if (dbg_gnt) begin
            mem_wen    = dbg_wen;
            mem_addr   = dbg_addr;
            mem_dat_in = dbg_wdat;
        end
    end

    assign rd_dat     = mem_dat_out;
    assign cpu_rvalid = cpu_rv_q;
    assign dbg_rvalid = dbg_rv_q;
    assign cnt_inc    = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);

    // Next state: the counter holds lock-owned cycles including the entry grant.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        forced_d = forced_q;
        cpu_rv_d = cpu_gnt & ~cpu_wen;
        dbg_rv_d = dbg_gnt & ~dbg_wen;
        unique case (state_q)
            ARB: begin
                if (!dbg_lock) forced_d = 1'b0;
                if (cpu_gnt) last_d = 1'b0;
                if (dbg_gnt) last_d = 1'b1;
                if (dbg_gnt && dbg_lock && !forced_q) begin
                    cnt_d = CW'(1);
                    if (MAX_LOCK <= 1) forced_d = 1'b1;
                    else state_d = LOCK;
                end
            end
            LOCK: begin
                cnt_d = cnt_inc;
                if (!dbg_lock) begin
                    state_d = ARB;
                    last_d  = 1'b1;
                end else if (cnt_inc == CMAX) begin
                    state_d  = ARB;
                    last_d   = 1'b1;
                    forced_d = 1'b1;
                end
            end
        endcase
    end

    // State and read-valid registers; reset leaves debug as last so CPU wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            forced_q <= 1'b0;
            cpu_rv_q <= 1'b0;
            dbg_rv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            forced_q <= forced_d;
            cpu_rv_q <= cpu_rv_d;
            dbg_rv_q <= dbg_rv_d;
        end
    end

endmodule

// File: tb/tb_main_mem_arb.sv
// Scoreboard bench for main_mem_arb: random and directed traffic against a
// cycle-level reference model, with a RAM model behind the memory port.
module tb_main_mem_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ML = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 0, cpu_wen = 0, dbg_req = 0, dbg_lock = 0, dbg_wen = 0;
    logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
    logic [DW-1:0] cpu_wdat = '0, dbg_wdat = '0;
    logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic          mem_cs, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] rd_dat, mem_dat_in, mem_dat_out;

    always #5 clk = ~clk;

    main_mem_arb #(.ADDR_W(AW), .DAT_W(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdat(cpu_wdat), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_wen(dbg_wen),
        .dbg_addr(dbg_addr), .dbg_wdat(dbg_wdat), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .rd_dat(rd_dat),
        .mem_cs(mem_cs), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_dat_in(mem_dat_in), .mem_dat_out(mem_dat_out)
    );

    // Synchronous RAM behind the arbiter: read data one cycle after the access.
    logic [DW-1:0] ram [128];
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_wen) ram[mem_addr[6:0]] <= mem_dat_in;
            else mem_dat_out <= ram[mem_addr[6:0]];
        end
    end

    typedef struct {
        int            port;
        int            due;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] ref_mem [128];
    int            nvec = 0, nerr = 0, cyc = 0;
    int            streak = 0, max_streak = 0;

    // Reference model: who owns the bus and who won the last contention.
    bit m_lock, m_last, m_block;
    int m_held;

    // Pending request of each port (held until granted).
    bit            cr, cw, dr, dw, dl, gc, gd;
    logic [AW-1:0] ca, da;
    logic [DW-1:0] cd, dd;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_lock  = 0;
        m_last  = 1;
        m_block = 0;
        m_held  = 0;
        q.delete();
    endtask

    task automatic cycle(bit rst);
        bit            ewen;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edin;
        #1;
        rst_n    = !rst;
        cpu_req  = cr; cpu_wen = cw; cpu_addr = ca; cpu_wdat = cd;
        dbg_req  = dr; dbg_wen = dw; dbg_addr = da; dbg_wdat = dd;
        dbg_lock = dl;
        if (rst) model_reset();
        gc = 0;
        gd = 0;
        if (m_lock) gd = dr;
        else if (cr && dr) begin
            if (m_last) gc = 1;
            else gd = 1;
        end else begin
            gc = cr;
            gd = dr;
        end
        ewen  = gc ? cw : (gd ? dw : 1'b0);
        eaddr = gc ? ca : (gd ? da : '0);
        edin  = gc ? cd : (gd ? dd : '0);
        #1;
        chk("cpu_gnt", cpu_gnt, gc);
        chk("dbg_gnt", dbg_gnt, gd);
        chk("mem_cs", mem_cs, gc | gd);
        chk("mem_wen", mem_wen, ewen);
        chk("mem_addr", mem_addr, eaddr);
        chk("mem_dat_in", mem_dat_in, edin);
        if (dbg_gnt && !cpu_gnt) streak++;
        else streak = 0;
        if (streak > max_streak) max_streak = streak;
        if ((gc || gd) && !ewen && !rst)
            q.push_back('{gc ? 0 : 1, cyc + 1, ref_mem[eaddr[6:0]]});
        if ((gc || gd) && ewen) ref_mem[eaddr[6:0]] = edin;
        if (!rst) begin
            if (m_lock) begin
                // One more owned cycle; drop on release or once the budget is used up.
                if (m_held < ML) m_held++;
                if (!dl) begin
                    m_lock = 0;
                    m_last = 1;
                end else if (m_held == ML) begin
                    m_lock  = 0;
                    m_last  = 1;
                    m_block = 1;
                end
            end else begin
                if (gc) m_last = 0;
                if (gd) m_last = 1;
                if (!dl) m_block = 0;
                if (gd && dl && !m_block) begin
                    m_lock = 1;
                    m_held = 1;
                end
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic rst_cycle(int n);
        repeat (n) cycle(1);
        cr = 0;
        dr = 0;
    endtask

    // mode < 0 picks randomly, otherwise the fixed value; percentages for requests.
    task automatic run(int n, int pc, int pd, int cwm, int dwm, int lkm);
        repeat (n) begin
            if (!cr || gc) begin
                cr = ($urandom % 100) < pc;
                cw = (cwm < 0) ? $urandom_range(0, 1) : cwm[0];
                ca = AW'($urandom % 64);
                cd = $urandom;
            end
            if (!dr || gd) begin
                dr = ($urandom % 100) < pd;
                dw = (dwm < 0) ? $urandom_range(0, 1) : dwm[0];
                da = AW'($urandom % 64);
                dd = $urandom;
            end
            dl = (lkm < 0) ? (($urandom % 100) < 85) : lkm[0];
            cycle(0);
        end
    endtask

    // Monitor: pops the scoreboard whenever a read return is due.
    bit            ec, ed;
    logic [DW-1:0] edat;
    exp_t          e;
    initial begin
        forever begin
            @(negedge clk);
            ec   = 0;
            ed   = 0;
            edat = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if (e.port == 0) ec = 1;
                else ed = 1;
                edat = e.dat;
            end
            chk("cpu_rvalid", cpu_rvalid, ec);
            chk("dbg_rvalid", dbg_rvalid, ed);
            if (ec || ed) chk("rd_dat", rd_dat, edat);
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram[i]     = DW'(i * 3 + 1);
            ref_mem[i] = DW'(i * 3 + 1);
        end
        model_reset();
        cr = 0; cw = 0; dr = 0; dw = 0; dl = 0; gc = 0; gd = 0;
        ca = '0; da = '0; cd = '0; dd = '0;
        rst_cycle(2);

        // Both reading continuously: alternation starting with the CPU.
        run(8, 100, 100, 0, 0, 0);
        run(1, 0, 0, 0, 0, 0);

        // Single CPU write.
        cr = 1; cw = 1; ca = 32'h40; cd = 32'hA5A5;
        dr = 0; dl = 0;
        cycle(0);
        cr = 0;
        run(2, 0, 0, 0, 0, 0);

        // Lock held with both requesting: bounded run, then no re-lock.
        streak = 0;
        max_streak = 0;
        run(30, 100, 100, 0, 0, 1);
        chk("lock_streak", 64'(max_streak), 64'(ML));
        run(3, 100, 100, 0, 0, 0);
        run(20, 100, 100, -1, -1, 1);

        // Lock with debug idle: CPU starves until the lock drops.
        run(2, 0, 0, 0, 0, 0);
        run(2, 0, 100, 0, 0, 1);
        run(3, 100, 0, 0, 0, 1);
        run(3, 100, 0, 0, 0, 0);

        // Reset mid-lock with a debug read in flight.
        run(2, 0, 0, 0, 0, 0);
        run(2, 0, 100, 0, 0, 1);
        cr = 0; dr = 1; dw = 0; da = 32'h8; dl = 1;
        rst_cycle(2);
        run(2, 100, 100, 0, 0, 0);

        // Random traffic with occasional resets.
        for (int k = 0; k < 10; k++) begin
            run(300, 60, 60, -1, -1, -1);
            rst_cycle(1);
        end
        run(200, 50, 70, -1, -1, -1);

        cr = 0;
        dr = 0;
        dl = 0;
        cycle(0);
        cycle(0);
        chk("drain", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
